// File: rtl/jelly_wishbone_pkg.sv
// Shared definitions for the jelly Wishbone bridge family: default bus widths
// and the initiator state encoding.
package jelly_wishbone_pkg;

    localparam int WB_ADR_WIDTH_DEFAULT = 30;
    localparam int WB_DAT_WIDTH_DEFAULT = 32;
    localparam int WB_SEL_WIDTH_DEFAULT = WB_DAT_WIDTH_DEFAULT / 8;

    // Initiator states: waiting for a command, running a bus cycle, holding a response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

endpackage

// File: rtl/jelly_wishbone_timeout_counter.sv
// Bus-cycle watchdog for the Wishbone initiator. Counts cycles while enabled
// and flags expiry once CYCLES cycles have been spent (count == CYCLES-1).
// Only instantiated when JELLY_WISHBONE_INITIATOR_TIMEOUT_EN is defined.
module jelly_wishbone_timeout_counter #(
    parameter int WIDTH  = 16,
    parameter int CYCLES = 1000
) (
    input  logic reset,
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(CYCLES - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear has priority; the count parks at LAST so it cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/jelly_wishbone_initiator.sv
// Wishbone classic initiator: turns a valid/ready command stream into single
// STB/ACK cycles and returns read data (and optionally write completions) on
// a valid/ready response stream. One transaction is in flight at a time.
//
// Optional feature macro: JELLY_WISHBONE_INITIATOR_TIMEOUT_EN
//   Defined   -> a bus cycle without ACK for TIMEOUT_CYCLES cycles is aborted
//                and reported with m_rsp_err=1.
//   Undefined -> the bus cycle waits for ACK indefinitely; m_rsp_err is 0.
module jelly_wishbone_initiator
    import jelly_wishbone_pkg::*;
#(
    parameter int WB_ADR_WIDTH   = WB_ADR_WIDTH_DEFAULT,
    parameter int WB_DAT_WIDTH   = WB_DAT_WIDTH_DEFAULT,
    parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
    parameter int WRITE_RESPONSE = 1,
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    reset,
    input  logic                    clk,

    input  logic [WB_ADR_WIDTH-1:0] s_cmd_adr,
    input  logic                    s_cmd_we,
    input  logic [WB_DAT_WIDTH-1:0] s_cmd_dat,
    input  logic [WB_SEL_WIDTH-1:0] s_cmd_sel,
    input  logic                    s_cmd_valid,
    output logic                    s_cmd_ready,

    output logic [WB_DAT_WIDTH-1:0] m_rsp_dat,
    output logic                    m_rsp_err,
    output logic                    m_rsp_valid,
    input  logic                    m_rsp_ready,

    output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
    input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
    output logic                    m_wb_we_o,
    output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
    output logic                    m_wb_stb_o,
    input  logic                    m_wb_ack_i
);

    wb_state_t                 state_q;
    wb_state_t                 state_d;
    logic [WB_ADR_WIDTH-1:0]   adr_q;
    logic [WB_ADR_WIDTH-1:0]   adr_d;
    logic [WB_DAT_WIDTH-1:0]   wdat_q;
    logic [WB_DAT_WIDTH-1:0]   wdat_d;
    logic                      we_q;
    logic                      we_d;
    logic [WB_SEL_WIDTH-1:0]   sel_q;
    logic [WB_SEL_WIDTH-1:0]   sel_d;
    logic [WB_DAT_WIDTH-1:0]   rsp_dat_q;
    logic [WB_DAT_WIDTH-1:0]   rsp_dat_d;
    logic                      timeout;

`ifdef JELLY_WISHBONE_INITIATOR_TIMEOUT_EN
    logic                      rsp_err_q;
    logic                      rsp_err_d;
    logic                      tmo_clear;
    logic                      tmo_enable;

    // The counter is held clear outside BUS, so every bus cycle starts from zero.
    // A cycle that carries ACK does not count towards the timeout.
    assign tmo_clear  = (state_q != ST_BUS);
    assign tmo_enable = (state_q == ST_BUS) && !m_wb_ack_i;

    jelly_wishbone_timeout_counter #(
        .WIDTH  (TIMEOUT_WIDTH),
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .reset   (reset),
        .clk     (clk),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (timeout)
    );

    assign m_rsp_err = rsp_err_q;
`else
    assign timeout   = 1'b0;
    assign m_rsp_err = 1'b0;

    // Timeout parameters have no effect in this build.
    if ((TIMEOUT_WIDTH < 1) || (TIMEOUT_CYCLES < 1)) begin : g_timeout_params_inactive
    end
`endif

    // Next state and datapath loads. ACK is only looked at in BUS, so a stray
    // ACK in IDLE or RESP is ignored; ACK also beats a simultaneous timeout.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        we_d      = we_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
`ifdef JELLY_WISHBONE_INITIATOR_TIMEOUT_EN
        rsp_err_d = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s_cmd_valid) begin
                    adr_d   = s_cmd_adr;
                    wdat_d  = s_cmd_dat;
                    we_d    = s_cmd_we;
                    sel_d   = s_cmd_sel;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (m_wb_ack_i) begin
                    rsp_dat_d = we_q ? '0 : m_wb_dat_i;
`ifdef JELLY_WISHBONE_INITIATOR_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                    // Silent writes skip the response beat entirely.
                    if (we_q && (WRITE_RESPONSE == 0)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (timeout) begin
                    // An abort is always reported, even for silent writes.
                    rsp_dat_d = '0;
`ifdef JELLY_WISHBONE_INITIATOR_TIMEOUT_EN
                    rsp_err_d = 1'b1;
`endif
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; everything resets to a known zero value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            wdat_q    <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
`ifdef JELLY_WISHBONE_INITIATOR_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
`ifdef JELLY_WISHBONE_INITIATOR_TIMEOUT_EN
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

    // Handshake outputs decode the state register only; reset masks ready so
    // no command can be taken while the block is being cleared.
    assign s_cmd_ready = (state_q == ST_IDLE) && !reset;
    assign m_wb_stb_o  = (state_q == ST_BUS);
    assign m_rsp_valid = (state_q == ST_RESP);

    assign m_wb_adr_o  = adr_q;
    assign m_wb_dat_o  = wdat_q;
    assign m_wb_we_o   = we_q;
    assign m_wb_sel_o  = sel_q;
    assign m_rsp_dat   = rsp_dat_q;

endmodule

// File: tb/tb_jelly_wishbone_initiator.sv
// Testbench for jelly_wishbone_initiator. Two instances run side by side:
// g_env[0] with write responses enabled, g_env[1] with silent writes.
// Each has a memory-backed Wishbone slave, a reference memory model and a
// response scoreboard. Timeout scenarios run when
// JELLY_WISHBONE_INITIATOR_TIMEOUT_EN is defined.
module tb_jelly_wishbone_initiator;

    localparam int AW     = 30;
    localparam int DW     = 32;
    localparam int SW     = 4;
    localparam int TO_CYC = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          done_e [2];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] sel);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < SW; b++) if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // Initial contents of every slave memory word.
    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int WR = (g == 0) ? 1 : 0;

        logic          rst = 1'b1;
        logic [AW-1:0] cmd_adr = '0;
        logic          cmd_we = 1'b0;
        logic [DW-1:0] cmd_dat = '0;
        logic [SW-1:0] cmd_sel = '0;
        logic          cmd_valid = 1'b0;
        logic          cmd_ready;
        logic [DW-1:0] rsp_dat;
        logic          rsp_err;
        logic          rsp_valid;
        logic          rsp_ready = 1'b0;
        logic [AW-1:0] wb_adr;
        logic [DW-1:0] wb_dat_i = '0;
        logic [DW-1:0] wb_dat_o;
        logic          wb_we;
        logic [SW-1:0] wb_sel;
        logic          wb_stb;
        logic          wb_ack = 1'b0;

        jelly_wishbone_initiator #(
            .WB_ADR_WIDTH   (AW),
            .WB_DAT_WIDTH   (DW),
            .WB_SEL_WIDTH   (SW),
            .WRITE_RESPONSE (WR),
            .TIMEOUT_WIDTH  (16),
            .TIMEOUT_CYCLES (TO_CYC)
        ) u_dut (
            .reset       (rst),
            .clk         (clk),
            .s_cmd_adr   (cmd_adr),
            .s_cmd_we    (cmd_we),
            .s_cmd_dat   (cmd_dat),
            .s_cmd_sel   (cmd_sel),
            .s_cmd_valid (cmd_valid),
            .s_cmd_ready (cmd_ready),
            .m_rsp_dat   (rsp_dat),
            .m_rsp_err   (rsp_err),
            .m_rsp_valid (rsp_valid),
            .m_rsp_ready (rsp_ready),
            .m_wb_adr_o  (wb_adr),
            .m_wb_dat_i  (wb_dat_i),
            .m_wb_dat_o  (wb_dat_o),
            .m_wb_we_o   (wb_we),
            .m_wb_sel_o  (wb_sel),
            .m_wb_stb_o  (wb_stb),
            .m_wb_ack_i  (wb_ack)
        );

        logic [DW-1:0] smem [logic [AW-1:0]];   // slave contents
        logic [DW-1:0] rmem [logic [AW-1:0]];   // reference model contents
        logic [32:0]   exp_q [$];               // {err, dat} expected responses

        // Command currently on the bus, recorded at acceptance.
        logic [AW-1:0] if_adr = '0;
        logic [DW-1:0] if_dat = '0;
        logic          if_we = 1'b0;
        logic [SW-1:0] if_sel = '0;
        bit            if_noack = 1'b0;
        int            if_target = 0;

        int  force_wait = -1;
        int  max_wait = 0;
        int  rdy_mode = 1;      // 0: hold low, 1: hold high, 2: random
        bit  noack = 1'b0;
        bit  abort = 1'b0;
        bit  stray_force = 1'b0;
        bit  tp_check = 1'b0;
        int  last_acc = -1;
        bit  last_rsp = 1'b1;

        int            run = 0;
        int            exp_len = 0;
        logic [DW-1:0] s_cur;
        logic          m_r;
        logic          held = 1'b0;
        logic [32:0]   prev_rsp = '0;
        logic [32:0]   m_e;

        // Slave: ACKs after the chosen wait, checks bus stability and STB length,
        // and throws stray ACKs while STB is low.
        initial forever begin
            @(negedge clk);
            if (wb_stb) begin
                if (run == 0) exp_len = if_noack ? TO_CYC : if_target + 1;
                check("wb_adr_stable", wb_adr, if_adr);
                check("wb_dat_o_stable", wb_dat_o, if_dat);
                check("wb_we_stable", wb_we, if_we);
                check("wb_sel_stable", wb_sel, if_sel);
                if (!if_noack && run == if_target) begin
                    s_cur = smem.exists(wb_adr) ? smem[wb_adr] : dflt(wb_adr);
                    if (wb_we) begin
                        smem[wb_adr] = merge(s_cur, wb_dat_o, wb_sel);
                        wb_dat_i = $urandom;
                    end else begin
                        wb_dat_i = s_cur;
                    end
                    wb_ack = 1'b1;
                end else begin
                    wb_ack = 1'b0;
                    wb_dat_i = $urandom;
                end
                run++;
            end else begin
                if (run != 0 && !abort) check("stb_len", run, exp_len);
                run = 0;
                wb_ack = stray_force || ($urandom_range(0, 7) == 0);
                wb_dat_i = $urandom;
            end
        end

        // Response monitor: drives rsp_ready, pops the scoreboard on each handshake.
        initial forever begin
            @(negedge clk);
            m_r = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            rsp_ready = m_r;
            check("stb_rsp_exclusive", wb_stb & rsp_valid, 0);
            if (wb_stb || rsp_valid) check("cmd_ready_while_busy", cmd_ready, 0);
            if (rsp_valid) begin
                if (held) begin
                    check("rsp_dat_stable", rsp_dat, prev_rsp[31:0]);
                    check("rsp_err_stable", rsp_err, prev_rsp[32]);
                end
                if (m_r) begin
                    check("rsp_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        m_e = exp_q.pop_front();
                        check("rsp_dat", rsp_dat, m_e[31:0]);
                        check("rsp_err", rsp_err, m_e[32]);
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    prev_rsp = {rsp_err, rsp_dat};
                end
            end else begin
                held = 1'b0;
            end
        end

        // Issue one command; the reference model decides its response at acceptance.
        task automatic send(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
            int t = 0;
            logic [DW-1:0] cur;
            cmd_adr = a; cmd_we = we; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
            while (!cmd_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!cmd_ready) begin
                check("cmd_accept_timeout", t, 0);
                cmd_valid = 1'b0;
                return;
            end
            if (tp_check && last_acc >= 0) check("accept_gap", cyc - last_acc, last_rsp ? 3 : 2);
            last_acc  = cyc;
            if_adr    = a; if_dat = d; if_we = we; if_sel = s;
            if_noack  = noack;
            if_target = noack ? -1 : (force_wait >= 0) ? force_wait : $urandom_range(0, max_wait);
            cur = rmem.exists(a) ? rmem[a] : dflt(a);
            if (noack) begin
                exp_q.push_back({1'b1, 32'h0});
                last_rsp = 1'b1;
            end else if (we) begin
                rmem[a] = merge(cur, d, s);
                if (WR != 0) exp_q.push_back({1'b0, 32'h0});
                last_rsp = (WR != 0);
            end else begin
                exp_q.push_back({1'b0, cur});
                last_rsp = 1'b1;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int t = 0;
            while ((exp_q.size() != 0 || wb_stb || rsp_valid) && t < 500) begin
                @(negedge clk);
                t++;
            end
            check("drain_cycles_under_500", t < 500, 1);
        endtask

        initial begin
            logic [DW-1:0] bp_dat;
            int            t;
            smem[AW'(32'h10)] = 32'hDEAD_BEEF;
            rmem[AW'(32'h10)] = 32'hDEAD_BEEF;

            // Reset state
            repeat (3) @(negedge clk);
            check("rst_cmd_ready", cmd_ready, 0);
            check("rst_stb", wb_stb, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_err", rsp_err, 0);
            check("rst_rsp_dat", rsp_dat, 0);
            check("rst_wb_adr", wb_adr, 0);
            check("rst_wb_dat_o", wb_dat_o, 0);
            check("rst_wb_we", wb_we, 0);
            check("rst_wb_sel", wb_sel, 0);
            rst = 1'b0;
            @(negedge clk);
            check("idle_cmd_ready", cmd_ready, 1);

            // Read with two wait states
            force_wait = 2;
            send(AW'(32'h10), 1'b0, 32'h0, 4'hF);
            force_wait = -1;
            wait_idle();

            // Partial write then read-back
            force_wait = 1;
            send(AW'(32'h20), 1'b1, 32'h1234_5678, 4'b0011);
            force_wait = -1;
            wait_idle();
            send(AW'(32'h20), 1'b0, 32'h0, 4'hF);
            wait_idle();

            // Back-to-back, zero-wait slave, response always taken
            max_wait = 0; tp_check = 1'b1; last_acc = -1;
            for (int i = 0; i < 10; i++)
                send(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, SW'($urandom_range(0, 15)));
            tp_check = 1'b0;
            wait_idle();

            // Response backpressure for 10 cycles
            rdy_mode = 0; force_wait = 0;
            send(AW'(32'h7), 1'b0, 32'h0, 4'hF);
            force_wait = -1;
            t = 0;
            while (!rsp_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("bp_rsp_valid_rise", rsp_valid, 1);
            bp_dat = rsp_dat;
            repeat (10) begin
                @(negedge clk);
                check("bp_rsp_valid", rsp_valid, 1);
                check("bp_rsp_dat", rsp_dat, bp_dat);
                check("bp_cmd_ready", cmd_ready, 0);
                check("bp_stb", wb_stb, 0);
            end
            rdy_mode = 1;
            wait_idle();

            // Reset in the middle of a bus cycle
            force_wait = 5;
            send(AW'(32'h5), 1'b0, 32'h0, 4'hF);
            force_wait = -1;
            @(negedge clk);
            abort = 1'b1;
            rst = 1'b1;
            void'(exp_q.pop_back());
            #1;
            check("midrst_cmd_ready", cmd_ready, 0);
            @(negedge clk);
            check("midrst_stb", wb_stb, 0);
            check("midrst_rsp_valid", rsp_valid, 0);
            rst = 1'b0;
            stray_force = 1'b1;
            repeat (4) @(negedge clk);
            check("midrst_no_late_rsp", rsp_valid, 0);
            stray_force = 1'b0;
            abort = 1'b0;
            send(AW'(32'h5), 1'b0, 32'h0, 4'hF);
            wait_idle();

`ifdef JELLY_WISHBONE_INITIATOR_TIMEOUT_EN
            // Timeouts on read and write, then ACK on the final allowed cycle
            noack = 1'b1;
            send(AW'(32'h3), 1'b0, 32'h0, 4'hF);
            send(AW'(32'h4), 1'b1, 32'hCAFE_F00D, 4'hF);
            noack = 1'b0;
            force_wait = TO_CYC - 1;
            send(AW'(32'h3), 1'b0, 32'h0, 4'hF);
            send(AW'(32'h4), 1'b0, 32'h0, 4'hF);
            force_wait = -1;
            wait_idle();
`endif

            // Randomized traffic
            rdy_mode = 2;
            for (int i = 0; i < 150; i++) begin
                max_wait = $urandom_range(0, 4);
`ifdef JELLY_WISHBONE_INITIATOR_TIMEOUT_EN
                noack = ($urandom_range(0, 15) == 0);
`endif
                send(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, SW'($urandom_range(0, 15)));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            noack = 1'b0;
            wait_idle();
            repeat (3) @(negedge clk);
            done_e[g] = 1'b1;
        end
    end

    initial begin
        fork
            wait (done_e[0] && done_e[1]);
            #500_000;
        join_any
        if (!(done_e[0] && done_e[1])) begin
            n_vec++;
            n_err++;
            $display("FAIL run_complete: got done=%b%b, required 11", done_e[1], done_e[0]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jelly_wishbone_initiator.md
Name: jelly_wishbone_initiator

Overview:
- Wishbone master that turns a valid/ready command stream into single Wishbone classic cycles (STB/ACK, same signal subset as the team's Wishbone bridges).
- Returns read data, and optionally write completions, on a valid/ready response stream.
- Sits between CPU-less control logic (DMA sequencers, debug/UART command decoders) and a Wishbone slave or bridge chain.
- One transaction is outstanding at a time.

Parameters:
- WB_ADR_WIDTH, 30, Wishbone word address width
- WB_DAT_WIDTH, 32, Wishbone data width
- WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width
- WRITE_RESPONSE, 1, 1: writes produce a response beat; 0: writes complete silently
- TIMEOUT_WIDTH, 16, timeout counter width (used only with the optional feature)
- TIMEOUT_CYCLES, 1000, cycles with STB high and no ACK before abort (used only with the optional feature)

Ports:
- reset  in  1  synchronous, active-high
- clk  in  1  clock
- s_cmd_adr  in  WB_ADR_WIDTH  command address
- s_cmd_we  in  1  1=write, 0=read
- s_cmd_dat  in  WB_DAT_WIDTH  write data
- s_cmd_sel  in  WB_SEL_WIDTH  byte enables
- s_cmd_valid  in  1  command valid
- s_cmd_ready  out  1  command accepted when valid&ready
- m_rsp_dat  out  WB_DAT_WIDTH  read data (0 for write responses)
- m_rsp_err  out  1  transaction aborted by timeout
- m_rsp_valid  out  1  response valid
- m_rsp_ready  in  1  response consumed when valid&ready
- m_wb_adr_o  out  WB_ADR_WIDTH  Wishbone address
- m_wb_dat_i  in  WB_DAT_WIDTH  Wishbone read data
- m_wb_dat_o  out  WB_DAT_WIDTH  Wishbone write data
- m_wb_we_o  out  1  Wishbone write enable
- m_wb_sel_o  out  WB_SEL_WIDTH  Wishbone byte select
- m_wb_stb_o  out  1  Wishbone strobe
- m_wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset values: m_wb_stb_o=0, m_rsp_valid=0, m_rsp_err=0; all data/address/sel/we registers =0 (no x); state=IDLE.
- s_cmd_ready is forced 0 while reset is high.
- State machine:
  - IDLE: s_cmd_ready=1. On valid&ready, latch adr/dat/we/sel into m_wb_* registers and go to BUS. m_wb_stb_o rises on the next cycle (1-cycle latency).
  - BUS: s_cmd_ready=0, m_wb_stb_o=1, all m_wb_* outputs held stable. A cycle with m_wb_ack_i=1 completes the transfer:
    - m_wb_dat_i is captured into m_rsp_dat (reads only; writes load 0).
    - m_wb_stb_o falls on the next edge.
    - Next state is RESP, except a write with WRITE_RESPONSE=0, which returns to IDLE.
  - RESP: m_rsp_valid=1, m_rsp_dat and m_rsp_err stable. On m_rsp_ready go to IDLE; m_rsp_valid falls on the next edge.
- m_wb_ack_i is ignored when m_wb_stb_o=0; a stray ACK has no effect.
- ACK in the first STB cycle is legal, giving minimum occupancy of 3 cycles per command (accept, BUS, RESP with ready held high).
- m_rsp_ready is allowed to be high before m_rsp_valid.
- Reset mid-transaction: STB drops at the next edge, any pending response is discarded, and no response is ever emitted for that command.
- No combinational path from m_wb_ack_i or m_rsp_ready to any output. All outputs are registered or decoded from the state register only.

Optional Feature:
- Macro: JELLY_WISHBONE_INITIATOR_TIMEOUT_EN.
- With the macro defined:
  - A TIMEOUT_WIDTH-bit counter clears on entry to BUS and increments each BUS cycle without ACK.
  - When the count reaches TIMEOUT_CYCLES-1 with no ACK, STB drops, and the block goes to RESP with m_rsp_err=1 and m_rsp_dat=0. This happens even for writes when WRITE_RESPONSE=0.
  - ACK arriving in the same cycle as the timeout wins: normal completion, err=0.
- Without the macro: BUS waits indefinitely, m_rsp_err is tied 0, and no counter logic is present.

Decomposition:
- Shared package/header jelly_wishbone_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_BUS=2'd1, ST_RESP=2'd2
  - default width constants, shared with the bridge family
- Sub-module: jelly_wishbone_timeout_counter (clear, enable, expired), instantiated only under the macro.
- Everything else stays in one module.

Test Plan:
- Read: cmd adr=0x10, we=0; slave ACKs 2 cycles after STB with 0xDEADBEEF -> STB high exactly 3 cycles, one response dat=0xDEADBEEF err=0; s_cmd_ready=0 throughout.
- Write, WRITE_RESPONSE=1 then 0: dat=0x12345678, sel=4'b0011 -> m_wb_dat_o/sel/we stable while STB high; response beat dat=0 in the first run, no response beat in the second; next command accepted 1 cycle after ACK.
- Back-to-back reads, zero-wait slave, rsp_ready tied 1 -> one command per 3 cycles; STB never high across a command boundary.
- Response backpressure: hold m_rsp_ready=0 for 10 cycles -> m_rsp_valid and m_rsp_dat stable, s_cmd_ready=0, STB=0 throughout.
- Reset asserted during BUS -> STB=0 and m_rsp_valid=0 after the edge; a later ACK causes no response; a new command works.
- With macro, TIMEOUT_CYCLES=8, slave never ACKs -> STB high exactly 8 cycles, response err=1 dat=0; repeat with ACK on cycle 8 -> err=0.
